// File: rtl/mul_sched_pkg.sv
// Shared definitions for the round-robin multiplier scheduler:
// FSM state encoding and the requester-index width helper.
package mul_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_RESP    = 2'd2
  } state_e;

  // Index width for n requesters; never narrower than one bit.
  function automatic int idw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/multiplier_nbit.sv
// Combinational unsigned multiplier returning the low WIDTH bits of a*b.
// IMPL_TYPE 0 uses the native operator, anything else a shift-add array.
module multiplier_nbit #(
  parameter int WIDTH     = 16,
  parameter int IMPL_TYPE = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] p
);

  generate
    if (IMPL_TYPE == 0) begin : g_direct
      assign p = a * b;
    end else begin : g_shift_add
      always_comb begin
        p = '0;
        for (int i = 0; i < WIDTH; i++) begin
          if (b[i]) p = p + (a << i);
        end
      end
    end
  endgenerate

endmodule

// File: rtl/mul_arb_rr.sv
// Round-robin arbiter in front of a single shared multiplier; one
// operation in flight, result held until the consumer takes it.
//
// state      | meaning
// -----------+-------------------------------------------------------
// ST_IDLE    | offer req_ready to the next requester after last grant
// ST_COMPUTE | registered operands feed the multiplier
// ST_RESP    | product and id held, resp_valid high until resp_ready
module mul_arb_rr
  import mul_sched_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int NUM_REQ   = 4,
  parameter int IMPL_TYPE = 0,
  localparam int IDW      = idw(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [WIDTH-1:0]         resp_p,
  output logic [IDW-1:0]           resp_id
);

  state_e           state_q, state_d;
  logic [IDW-1:0]   last_grant_q, last_grant_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] mul_p;

  logic             found;
  logic [IDW-1:0]   grant_idx;
  logic [IDW-1:0]   cand_idx;
  int               cand;

  // Search starts just after the last winner so every requester gets a turn.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand     = (int'(last_grant_q) + k) % NUM_REQ;
      cand_idx = IDW'(cand);
      if (!found && req_valid[cand_idx]) begin
        found     = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= IDW'(NUM_REQ - 1);
      id_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      p_q          <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      a_q          <= a_d;
      b_q          <= b_d;
      p_q          <= p_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    a_d          = a_q;
    b_d          = b_q;
    p_d          = p_q;
    unique case (state_q)
      ST_IDLE: begin
        if (found) begin
          a_d          = req_a[int'(grant_idx)*WIDTH +: WIDTH];
          b_d          = req_b[int'(grant_idx)*WIDTH +: WIDTH];
          id_d         = grant_idx;
          last_grant_d = grant_idx;
          state_d      = ST_COMPUTE;
        end
      end
      ST_COMPUTE: begin
        p_d     = mul_p;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (state_q == ST_IDLE && found && !rst) req_ready[grant_idx] = 1'b1;
    resp_valid = (state_q == ST_RESP);
  end

  assign resp_p  = p_q;
  assign resp_id = id_q;

  multiplier_nbit #(
    .WIDTH    (WIDTH),
    .IMPL_TYPE(IMPL_TYPE)
  ) u_mul (
    .a(a_q),
    .b(b_q),
    .p(mul_p)
  );

endmodule

// File: tb/tb_mul_arb_rr.sv
// Scoreboard bench for mul_arb_rr: accepts push expected products,
// consumed responses pop and compare; directed tests check grant order.
module tb_mul_arb_rr;

  localparam int W = 16;
  localparam int N = 4;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic           resp_valid;
  logic           resp_ready;
  logic [W-1:0]   resp_p;
  logic [1:0]     resp_id;

  mul_arb_rr #(.WIDTH(W), .NUM_REQ(N), .IMPL_TYPE(0)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_p    (resp_p),
    .resp_id   (resp_id)
  );

  typedef struct {
    logic [W-1:0] p;
    logic [1:0]   id;
    int           acc_cyc;
  } exp_t;

  exp_t         sb_q[$];
  int           grant_log[$];
  int           grant_cyc[$];
  logic [W-1:0] resp_log[$];

  int           n_tests = 0;
  int           n_fail  = 0;
  int           cyc     = 0;
  logic [N-1:0] auto_drop;
  logic         held;
  logic         prev_valid;
  logic         bench_idle;
  logic [W-1:0] hold_p;
  logic [1:0]   hold_id;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] mul_model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] full;
    full = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    return full[W-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic drop);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    auto_drop[i]    = drop;
    req_valid[i]    = 1'b1;
  endtask

  task automatic clear_logs();
    grant_log.delete();
    grant_cyc.delete();
    resp_log.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_grants(input int n, input int budget);
    int k;
    k = 0;
    while (grant_log.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk("wait_grants", grant_log.size() >= n, 1'b1);
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while ((sb_q.size() > 0 || !bench_idle || resp_valid || |req_valid) && k < budget) begin
      tick();
      k++;
    end
    chk("drain", (sb_q.size() == 0) && !resp_valid, 1'b1);
  endtask

  // Monitor: samples on the falling edge, between input changes and DUT edges.
  initial begin
    int   g;
    exp_t e;
    held       = 1'b0;
    prev_valid = 1'b0;
    bench_idle = 1'b1;
    forever begin
      @(negedge clk);
      g = -1;
      if (rst) begin
        chk("rst_ready_zero", req_ready, '0);
        sb_q.delete();
        held       = 1'b0;
        prev_valid = 1'b0;
        bench_idle = 1'b1;
      end else begin
        chk("ready_onehot0", $countones(req_ready) <= 1, 1'b1);
        chk("ready_implies_valid", |(req_ready & ~req_valid), 1'b0);
        if (bench_idle && |req_valid) chk("idle_grant", |req_ready, 1'b1);
        if (resp_valid) begin
          chk("busy_ready_zero", req_ready, '0);
          if (held) begin
            chk("hold_p", resp_p, hold_p);
            chk("hold_id", resp_id, hold_id);
          end
          chk("resp_expected", sb_q.size() > 0, 1'b1);
          if (sb_q.size() > 0) begin
            if (!prev_valid) chk("latency", cyc - sb_q[0].acc_cyc, 2);
            if (resp_ready) begin
              e = sb_q.pop_front();
              chk("resp_p", resp_p, e.p);
              chk("resp_id", resp_id, e.id);
              resp_log.push_back(resp_p);
              held       = 1'b0;
              bench_idle = 1'b1;
            end else begin
              held    = 1'b1;
              hold_p  = resp_p;
              hold_id = resp_id;
            end
          end
        end else begin
          held = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
          if (req_valid[i] && req_ready[i]) g = i;
        end
        if (g >= 0) begin
          e.p       = mul_model(req_a[g*W +: W], req_b[g*W +: W]);
          e.id      = 2'(g);
          e.acc_cyc = cyc;
          sb_q.push_back(e);
          grant_log.push_back(g);
          grant_cyc.push_back(cyc);
          bench_idle = 1'b0;
        end
        prev_valid = resp_valid;
        if (g >= 0 && auto_drop[g]) begin
          @(posedge clk);
          #1;
          req_valid[g] = 1'b0;
        end
      end
    end
  end

  initial begin
    int           n0;
    int           k;
    int           exp_ids[5];
    logic [W-1:0] exp_ps[5];
    logic         got3;

    rst        = 1'b1;
    req_valid  = '1;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b1;
    auto_drop  = '1;
    repeat (3) tick();
    chk("reset_resp_valid", resp_valid, 1'b0);
    chk("reset_resp_p", resp_p, '0);
    chk("reset_resp_id", resp_id, '0);
    req_valid = '0;
    rst       = 1'b0;
    tick();

    // single request from requester 2
    clear_logs();
    set_req(2, 16'd3, 16'd5, 1'b1);
    wait_grants(1, 20);
    if (grant_log.size() > 0) chk("single_id", grant_log[0], 2);
    drain(30);
    if (resp_log.size() > 0) chk("single_p", resp_log[0], 16'h000F);

    // modulo wrap-around
    clear_logs();
    set_req(0, 16'hFFFF, 16'hFFFF, 1'b1);
    wait_grants(1, 20);
    drain(30);
    set_req(1, 16'h0100, 16'h0100, 1'b1);
    wait_grants(1, 20);
    drain(30);
    chk("wrap_count", resp_log.size(), 2);
    if (resp_log.size() == 2) begin
      chk("wrap_ffff", resp_log[0], 16'h0001);
      chk("wrap_0100", resp_log[1], 16'h0000);
    end

    // contention: all four valid from reset
    do_reset();
    clear_logs();
    for (int i = 0; i < N; i++) set_req(i, 16'(i + 1), 16'd10, 1'b0);
    wait_grants(5, 60);
    req_valid = '0;
    drain(30);
    exp_ids = '{0, 1, 2, 3, 0};
    exp_ps  = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd10};
    if (grant_log.size() >= 5 && resp_log.size() >= 5) begin
      for (int i = 0; i < 5; i++) begin
        chk("cont_grant", grant_log[i], exp_ids[i]);
        chk("cont_p", resp_log[i], exp_ps[i]);
        if (i > 0) chk("cont_interval", grant_cyc[i] - grant_cyc[i-1], 3);
      end
    end

    // backpressure with another request pending
    clear_logs();
    resp_ready = 1'b0;
    set_req(1, 16'd7, 16'd9, 1'b1);
    k = 0;
    while (!resp_valid && k < 20) begin
      tick();
      k++;
    end
    chk("bp_wait", resp_valid, 1'b1);
    set_req(3, 16'd2, 16'd3, 1'b1);
    repeat (5) begin
      tick();
      chk("bp_valid", resp_valid, 1'b1);
      chk("bp_p", resp_p, 16'd63);
      chk("bp_id", resp_id, 2'd1);
      chk("bp_ready", req_ready, '0);
    end
    resp_ready = 1'b1;
    tick();
    chk("bp_consumed", resp_valid, 1'b0);
    drain(30);
    chk("bp_count", resp_log.size(), 2);
    if (resp_log.size() == 2) begin
      chk("bp_first", resp_log[0], 16'd63);
      chk("bp_second", resp_log[1], 16'd6);
    end

    // reset in the middle of an operation
    clear_logs();
    set_req(1, 16'd4, 16'd4, 1'b1);
    wait_grants(1, 20);
    rst = 1'b1;
    set_req(3, 16'd5, 16'd5, 1'b1);
    set_req(0, 16'd6, 16'd6, 1'b1);
    tick();
    rst = 1'b0;
    chk("rmid_valid", resp_valid, 1'b0);
    chk("rmid_p", resp_p, '0);
    chk("rmid_id", resp_id, '0);
    clear_logs();
    wait_grants(2, 40);
    if (grant_log.size() >= 2) begin
      chk("rmid_first", grant_log[0], 0);
      chk("rmid_second", grant_log[1], 3);
    end
    drain(30);
    chk("rmid_count", resp_log.size(), 2);
    if (resp_log.size() == 2) begin
      chk("rmid_p0", resp_log[0], 16'd36);
      chk("rmid_p3", resp_log[1], 16'd25);
    end

    // fairness against a continuously valid requester
    do_reset();
    clear_logs();
    set_req(1, 16'd1, 16'd1, 1'b0);
    wait_grants(1, 20);
    set_req(3, 16'd3, 16'd3, 1'b1);
    n0 = grant_log.size();
    wait_grants(n0 + 2, 40);
    got3 = 1'b0;
    if (grant_log.size() >= n0 + 2) got3 = (grant_log[n0] == 3) || (grant_log[n0+1] == 3);
    chk("fair_req3", got3, 1'b1);
    tick();
    req_valid = '0;
    drain(30);

    chk("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
